ntt_stage_sched: RTL and testbench

//  Controls an in-place Cooley-Tukey forward NTT of N coefficients, running over all LOG_N stages.

---
 rtl/ntt_pkg.sv | 39 +++
 rtl/ntt_addr_gen.sv | 49 ++++
 rtl/ntt_stage_sched.sv | 212 +++++++++++++++++++++
 tb/tb_ntt_stage_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared types and helpers for the NTT stage schedulers.
//                Holds the scheduler state encoding, the default pipeline
//                latency (RAM/ROM read latency + butterfly core latency)
//                and a ceil(log2) helper usable in constant expressions.
//  Revision    : 1.0  initial release
// ============================================================================
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int unsigned DEF_RD_LAT   = 1;
    localparam int unsigned DEF_CORE_LAT = 1;
    localparam int unsigned PIPE_LAT     = DEF_RD_LAT + DEF_CORE_LAT;

    // ceil(log2(v)); returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 31) && ((32'd1 << r) < v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of the stage index: enough to hold 0..LOG_N-1, never zero.
    function automatic int unsigned stage_width(input int unsigned log_n);
        return (log_n > 1) ? clog2(log_n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_addr_gen
//  Description : Purely combinational butterfly address generator for a
//                SEAL-ordered Cooley-Tukey NTT. For stage s and butterfly
//                counter k:
//                    t = N >> (s+1),  i = k >> (LOG_N-1-s)
//                    j = (i << (LOG_N-s)) | (k & (t-1))
//                    addr_a = j, addr_b = j + t, tw_idx = (1 << s) + i
//                Shared by the forward and inverse schedulers.
//  Ports       : i_stage  [STAGE_W] stage s
//                i_k      [LOG_N]   butterfly counter k (0..N/2-1)
//                o_addr_a [LOG_N]   coefficient address j
//                o_addr_b [LOG_N]   coefficient address j+t
//                o_tw_idx [LOG_N]   twiddle index m+i
//  Revision    : 1.0  initial release
// ============================================================================
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter  int unsigned LOG_N   = 10,
    localparam int unsigned STAGE_W = stage_width(LOG_N)
) (
    input  logic [STAGE_W-1:0] i_stage,
    input  logic [LOG_N-1:0]   i_k,
    output logic [LOG_N-1:0]   o_addr_a,
    output logic [LOG_N-1:0]   o_addr_b,
    output logic [LOG_N-1:0]   o_tw_idx
);

    logic [LOG_N-1:0] w_shamt;
    logic [LOG_N-1:0] w_t;
    logic [LOG_N-1:0] w_i;
    logic [LOG_N-1:0] w_j;

    always_comb begin
        // log2(t) = LOG_N-1-s; the group index i is k with the low
        // log2(t) bits stripped, j re-inserts a zero bit above them.
        w_shamt  = LOG_N'(LOG_N - 1) - LOG_N'(i_stage);
        w_t      = LOG_N'(1) << w_shamt;
        w_i      = i_k >> w_shamt;
        w_j      = (w_i << (w_shamt + LOG_N'(1))) | (i_k & (w_t - LOG_N'(1)));
        o_addr_a = w_j;
        o_addr_b = w_j + w_t;
        o_tw_idx = (LOG_N'(1) << i_stage) + w_i;
    end

endmodule
`default_nettype wire

// File: rtl/ntt_stage_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_stage_sched
//  Description : Scheduler for an in-place forward NTT over all LOG_N
//                stages. Issues one butterfly per cycle: reads a coefficient
//                pair and a twiddle, feeds the butterfly core directly from
//                the read data, and writes the core results back to the
//                same addresses PIPE_LAT = RD_LAT + CORE_LAT cycles later.
//                A drain of PIPE_LAT cycles separates stages so every write
//                of one stage lands before the next stage reads.
//  Ports       : clk, reset (sync, active-high), start (pulse)
//                busy / done / stage          status
//                rd_en, rd_addr_a/b, tw_addr  RAM / twiddle ROM read side
//                rd_data_a/b, tw_w, tw_wp     read data (RD_LAT later)
//                core_a/b/w/wp                butterfly core inputs
//                core_ya/yb                   butterfly core outputs
//                wr_en, wr_addr_a/b, wr_data_a/b  RAM write side
//  Revision    : 1.0  initial release
// ============================================================================
module ntt_stage_sched
    import ntt_pkg::*;
#(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned LOG_N    = 10,
    parameter  int unsigned RD_LAT   = DEF_RD_LAT,
    parameter  int unsigned CORE_LAT = DEF_CORE_LAT,
    localparam int unsigned STAGE_W  = stage_width(LOG_N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [STAGE_W-1:0]  stage,
    output logic                rd_en,
    output logic [LOG_N-1:0]    rd_addr_a,
    output logic [LOG_N-1:0]    rd_addr_b,
    input  logic [DATA_W-1:0]   rd_data_a,
    input  logic [DATA_W-1:0]   rd_data_b,
    output logic [LOG_N-1:0]    tw_addr,
    input  logic [DATA_W-1:0]   tw_w,
    input  logic [DATA_W-1:0]   tw_wp,
    output logic [DATA_W-1:0]   core_a,
    output logic [DATA_W-1:0]   core_b,
    output logic [DATA_W-1:0]   core_w,
    output logic [DATA_W-1:0]   core_wp,
    input  logic [DATA_W-1:0]   core_ya,
    input  logic [DATA_W-1:0]   core_yb,
    output logic                wr_en,
    output logic [LOG_N-1:0]    wr_addr_a,
    output logic [LOG_N-1:0]    wr_addr_b,
    output logic [DATA_W-1:0]   wr_data_a,
    output logic [DATA_W-1:0]   wr_data_b
);

    localparam int unsigned         C_PIPE_LAT   = RD_LAT + CORE_LAT;
    localparam int unsigned         C_DRAIN_W    = (C_PIPE_LAT > 1) ? clog2(C_PIPE_LAT) : 1;
    localparam logic [LOG_N-1:0]    C_K_LAST     = LOG_N'((1 << (LOG_N - 1)) - 1);
    localparam logic [STAGE_W-1:0]  C_STAGE_LAST = STAGE_W'(LOG_N - 1);
    localparam logic [C_DRAIN_W-1:0] C_DRAIN_LAST = C_DRAIN_W'(C_PIPE_LAT - 1);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    sched_state_t           state_q, state_d;
    logic [STAGE_W-1:0]     stage_q, stage_d;
    logic [LOG_N-1:0]       k_q, k_d;
    logic [C_DRAIN_W-1:0]   drain_q, drain_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                // Start is only honoured here, so a pulse while running is dropped.
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                k_d = k_q + LOG_N'(1);
                if (k_q == C_K_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + C_DRAIN_W'(1);
                if (drain_q == C_DRAIN_LAST) begin
                    if (stage_q == C_STAGE_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + STAGE_W'(1);
                        k_d     = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read side: addresses are forced to zero outside RUN so the RAM/ROM
    // buses stay quiet while idle or draining.
    // ------------------------------------------------------------------
    logic [LOG_N-1:0] w_addr_a;
    logic [LOG_N-1:0] w_addr_b;
    logic [LOG_N-1:0] w_tw_idx;
    logic             w_rd_en;

    ntt_addr_gen #(
        .LOG_N    (LOG_N)
    ) u_addr_gen (
        .i_stage  (stage_q),
        .i_k      (k_q),
        .o_addr_a (w_addr_a),
        .o_addr_b (w_addr_b),
        .o_tw_idx (w_tw_idx)
    );

    assign w_rd_en   = (state_q == RUN);
    assign rd_en     = w_rd_en;
    assign rd_addr_a = w_rd_en ? w_addr_a : '0;
    assign rd_addr_b = w_rd_en ? w_addr_b : '0;
    assign tw_addr   = w_rd_en ? w_tw_idx : '0;

    // ------------------------------------------------------------------
    // Write-back: the read strobe and addresses ride a PIPE_LAT-deep shift
    // register so they line up with the core results.
    // ------------------------------------------------------------------
    logic [C_PIPE_LAT-1:0] wr_en_pipe_q, wr_en_pipe_d;
    logic [LOG_N-1:0]      wa_pipe_q [C_PIPE_LAT];
    logic [LOG_N-1:0]      wa_pipe_d [C_PIPE_LAT];
    logic [LOG_N-1:0]      wb_pipe_q [C_PIPE_LAT];
    logic [LOG_N-1:0]      wb_pipe_d [C_PIPE_LAT];

    always_comb begin
        wr_en_pipe_d    = wr_en_pipe_q;
        wa_pipe_d       = wa_pipe_q;
        wb_pipe_d       = wb_pipe_q;
        wr_en_pipe_d[0] = w_rd_en;
        wa_pipe_d[0]    = rd_addr_a;
        wb_pipe_d[0]    = rd_addr_b;
        for (int n = 1; n < int'(C_PIPE_LAT); n++) begin
            wr_en_pipe_d[n] = wr_en_pipe_q[n-1];
            wa_pipe_d[n]    = wa_pipe_q[n-1];
            wb_pipe_d[n]    = wb_pipe_q[n-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Clearing the pipe aborts any in-flight writes immediately.
            wr_en_pipe_q <= '0;
            for (int n = 0; n < int'(C_PIPE_LAT); n++) begin
                wa_pipe_q[n] <= '0;
                wb_pipe_q[n] <= '0;
            end
        end else begin
            wr_en_pipe_q <= wr_en_pipe_d;
            wa_pipe_q    <= wa_pipe_d;
            wb_pipe_q    <= wb_pipe_d;
        end
    end

    assign wr_en     = wr_en_pipe_q[C_PIPE_LAT-1];
    assign wr_addr_a = wa_pipe_q[C_PIPE_LAT-1];
    assign wr_addr_b = wb_pipe_q[C_PIPE_LAT-1];
    assign wr_data_a = core_ya;
    assign wr_data_b = core_yb;

    // Core operands come straight from the memories, no extra register.
    assign core_a  = rd_data_a;
    assign core_b  = rd_data_b;
    assign core_w  = tw_w;
    assign core_wp = tw_wp;

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    assign busy  = (state_q == RUN) || (state_q == DRAIN);
    assign done  = (state_q == DONE);
    assign stage = stage_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_stage_sched
//  Description : Self-checking bench for ntt_stage_sched with LOG_N=3 (N=8),
//                q=7681, a 1-cycle RAM/ROM model and a 1-cycle butterfly
//                model (ya = a + w*b, yb = a - w*b mod q).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ntt_stage_sched;

    localparam int    LOG_N  = 3;
    localparam int    N      = 8;
    localparam int    DATA_W = 32;
    localparam longint Q     = 7681;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, rd_en, wr_en;
    logic [1:0]        stage;
    logic [2:0]        rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
    logic [31:0]       rd_data_a = '0, rd_data_b = '0, tw_w = '0, tw_wp = '0;
    logic [31:0]       core_a, core_b, core_w, core_wp;
    logic [31:0]       core_ya = '0, core_yb = '0;
    logic [31:0]       wr_data_a, wr_data_b;

    always #5 clk = ~clk;

    ntt_stage_sched #(
        .DATA_W   (DATA_W),
        .LOG_N    (LOG_N),
        .RD_LAT   (1),
        .CORE_LAT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .tw_addr   (tw_addr),
        .tw_w      (tw_w),
        .tw_wp     (tw_wp),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_w    (core_w),
        .core_wp   (core_wp),
        .core_ya   (core_ya),
        .core_yb   (core_yb),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .wr_data_a (wr_data_a),
        .wr_data_b (wr_data_b)
    );

    // ---------------- memory, ROM and core models ----------------
    logic [31:0] mem   [N];
    logic [31:0] rom_w [N];
    logic [31:0] rom_wp[N];
    logic        load_en = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (wr_en) begin
            mem[wr_addr_a] <= wr_data_a;
            mem[wr_addr_b] <= wr_data_b;
        end
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
            tw_w      <= rom_w[tw_addr];
            tw_wp     <= rom_wp[tw_addr];
        end
    end

    always @(posedge clk) begin
        core_ya <= 32'((64'(core_a) + (64'(core_w) * 64'(core_b)) % 64'(Q)) % 64'(Q));
        core_yb <= 32'((64'(core_a) + 64'(Q) - (64'(core_w) * 64'(core_b)) % 64'(Q)) % 64'(Q));
    end

    // ---------------- negedge monitor ----------------
    int rd_stg[16], rd_a[16], rd_b[16], rd_tw[16], rd_off[16];
    int wr_a[16], wr_b[16], wr_off[16];
    longint ca_a[16], ca_b[16];
    int rd_n = 0, wr_n = 0, ca_n = 0, busy_n = 0, off = 0, done_off = -1;
    logic busy_prev = 1'b0, rd_en_prev = 1'b0;

    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            off = 0; rd_n = 0; wr_n = 0; ca_n = 0; busy_n = 0; done_off = -1;
        end else begin
            off = off + 1;
        end
        if (busy) busy_n = busy_n + 1;
        if (rd_en_prev && ca_n < 16) begin
            ca_a[ca_n] = longint'(core_a);
            ca_b[ca_n] = longint'(core_b);
            ca_n = ca_n + 1;
        end
        if (rd_en && rd_n < 16) begin
            rd_stg[rd_n] = int'(stage);
            rd_a[rd_n]   = int'(rd_addr_a);
            rd_b[rd_n]   = int'(rd_addr_b);
            rd_tw[rd_n]  = int'(tw_addr);
            rd_off[rd_n] = off;
            rd_n = rd_n + 1;
        end
        if (wr_en && wr_n < 16) begin
            wr_a[wr_n]   = int'(wr_addr_a);
            wr_b[wr_n]   = int'(wr_addr_b);
            wr_off[wr_n] = off;
            wr_n = wr_n + 1;
        end
        if (done) done_off = off;
        busy_prev  = busy;
        rd_en_prev = rd_en;
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint powmod(input longint b, input longint e);
        longint r, bb, ee;
        r = 1; bb = b % Q; ee = e;
        while (ee > 0) begin
            if ((ee & 1) != 0) r = (r * bb) % Q;
            bb = (bb * bb) % Q;
            ee = ee >> 1;
        end
        return r;
    endfunction

    function automatic int bitrev3(input int x);
        return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
    endfunction

    // Golden SEAL-style forward NTT, written as the textbook nested loop.
    longint g_s0[N], g_fin[N];

    task automatic compute_golden();
        longint a[N];
        longint u, v;
        int m, t, j1;
        for (int x = 0; x < N; x++) a[x] = longint'(x);
        for (int s = 0; s < LOG_N; s++) begin
            m = 1 << s;
            t = N >> (s + 1);
            for (int i = 0; i < m; i++) begin
                j1 = 2 * i * t;
                for (int j = j1; j < j1 + t; j++) begin
                    u = a[j];
                    v = (a[j + t] * longint'(rom_w[m + i])) % Q;
                    a[j]     = (u + v) % Q;
                    a[j + t] = (u + Q - v) % Q;
                end
            end
            if (s == 0) for (int x = 0; x < N; x++) g_s0[x] = a[x];
        end
        for (int x = 0; x < N; x++) g_fin[x] = a[x];
    endtask

    task automatic load_ramp();
        for (int x = 0; x < N; x++) begin
            load_en   = 1'b1;
            load_addr = 3'(x);
            load_data = 32'(x);
            tick();
        end
        load_en = 1'b0;
    endtask

    // Expected butterfly order: stage, read pair, twiddle, cycle after busy rise.
    typedef struct {
        int stg;
        int ra;
        int rb;
        int tw;
        int off;
    } vec_t;
    vec_t tbl[12];

    task automatic run_and_check(input string tag);
        int cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_rise"}, longint'(busy), 1);
        cnt = 0;
        while (!done && cnt < 200) begin
            tick();
            cnt = cnt + 1;
        end
        chk({tag, "_done_seen"}, longint'(done), 1);
        @(negedge clk);
        #1;
        chk({tag, "_done_offset"}, done_off, 18);
        chk({tag, "_busy_len"}, busy_n, 18);
        chk({tag, "_rd_count"}, rd_n, 12);
        chk({tag, "_wr_count"}, wr_n, 12);
        for (int n = 0; n < 12; n++) begin
            chk($sformatf("%s_rd_stage_%0d", tag, n), rd_stg[n], tbl[n].stg);
            chk($sformatf("%s_rd_a_%0d", tag, n), rd_a[n], tbl[n].ra);
            chk($sformatf("%s_rd_b_%0d", tag, n), rd_b[n], tbl[n].rb);
            chk($sformatf("%s_tw_%0d", tag, n), rd_tw[n], tbl[n].tw);
            chk($sformatf("%s_rd_off_%0d", tag, n), rd_off[n], tbl[n].off);
            chk($sformatf("%s_wr_a_%0d", tag, n), wr_a[n], tbl[n].ra);
            chk($sformatf("%s_wr_b_%0d", tag, n), wr_b[n], tbl[n].rb);
            chk($sformatf("%s_wr_off_%0d", tag, n), wr_off[n], tbl[n].off + 2);
        end
        // First stage-1 butterfly reads (0,2) and must see stage-0 results.
        chk({tag, "_s1_raw_a"}, ca_a[4], g_s0[0]);
        chk({tag, "_s1_raw_b"}, ca_b[4], g_s0[2]);
        for (int x = 0; x < N; x++) begin
            chk($sformatf("%s_mem_%0d", tag, x), longint'(mem[x]), g_fin[x]);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        longint psi;

        tbl[0]  = '{0, 0, 4, 1, 0};
        tbl[1]  = '{0, 1, 5, 1, 1};
        tbl[2]  = '{0, 2, 6, 1, 2};
        tbl[3]  = '{0, 3, 7, 1, 3};
        tbl[4]  = '{1, 0, 2, 2, 6};
        tbl[5]  = '{1, 1, 3, 2, 7};
        tbl[6]  = '{1, 4, 6, 3, 8};
        tbl[7]  = '{1, 5, 7, 3, 9};
        tbl[8]  = '{2, 0, 1, 4, 12};
        tbl[9]  = '{2, 2, 3, 5, 13};
        tbl[10] = '{2, 4, 5, 6, 14};
        tbl[11] = '{2, 6, 7, 7, 15};

        psi = powmod(17, 480);
        for (int x = 0; x < N; x++) begin
            rom_w[x]  = 32'(powmod(psi, longint'(bitrev3(x))));
            rom_wp[x] = 32'((longint'(rom_w[x]) << 32) / Q);
            mem[x]    = '0;
        end
        compute_golden();

        // Reset with start held high: everything stays quiet.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        chk("reset_outputs",
            longint'({rd_en, wr_en, busy, done, stage, rd_addr_a, rd_addr_b,
                      tw_addr, wr_addr_a, wr_addr_b}), 0);
        chk("reset_busy", longint'(busy), 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("post_reset_busy", longint'(busy), 0);
        chk("post_reset_stage", longint'(stage), 0);

        // Full transform.
        load_ramp();
        run_and_check("run1");
        tick();
        chk("idle_after_done", longint'({busy, done, rd_en, wr_en}), 0);

        // Mid-run start is ignored; reset at stage 1, k=2 aborts.
        load_ramp();
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!(stage == 2'd1 && rd_en && rd_addr_a == 3'd4) && cnt < 50) begin
            start = (cnt == 2);
            tick();
            cnt = cnt + 1;
        end
        start = 1'b0;
        chk("abort_point_offset", cnt, 8);
        chk("abort_point_rd_b", longint'(rd_addr_b), 6);
        chk("abort_point_tw", longint'(tw_addr), 3);
        reset = 1'b1;
        tick();
        chk("abort_wr_en", longint'(wr_en), 0);
        chk("abort_state", longint'({busy, done, rd_en, stage}), 0);
        reset = 1'b0;
        tick();
        chk("abort_idle_busy", longint'(busy), 0);

        // A fresh start after the abort runs cleanly.
        load_ramp();
        run_and_check("run2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
